// File: rtl/skew_realigner_pkg.sv
// Shared types and constants for the lane skew realigner.
package skew_realigner_pkg;

  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned DROP_CNT_W    = 8;
  localparam int unsigned CNT_W         = 2;

  typedef enum logic {
    ALIGNED = 1'b0,
    SETTLE  = 1'b1
  } state_e;

endpackage

// File: rtl/skew_realigner_if.sv
// Lane bus between the upstream skewed stage and the realigned consumer.
interface skew_realigner_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LANES     = 4
);
  import skew_realigner_pkg::*;

  logic                        in_valid;
  logic [LANES*WORD_SIZE-1:0]  in_data;
  logic [LANES-1:0]            lane_shift_en;
  logic                        out_valid;
  logic [LANES*WORD_SIZE-1:0]  out_data;
  logic                        realign_busy;
  logic [DROP_CNT_W-1:0]       drop_count;

  modport master (
    output in_valid, in_data, lane_shift_en,
    input  out_valid, out_data, realign_busy, drop_count
  );

  modport slave (
    input  in_valid, in_data, lane_shift_en,
    output out_valid, out_data, realign_busy, drop_count
  );

endinterface

// File: rtl/skew_realigner_lane_delay.sv
// One lane: one register stage when the lane already arrives late, two otherwise.
module lane_delay #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en_i,
  input  logic [WORD_SIZE-1:0] din_i,
  output logic [WORD_SIZE-1:0] dout_o
);

  logic [WORD_SIZE-1:0] stage1_q;
  logic [WORD_SIZE-1:0] dout_q;

  // Late lanes bypass stage1 so both paths land in the same output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      dout_q   <= '0;
    end else begin
      stage1_q <= din_i;
      dout_q   <= shift_en_i ? din_i : stage1_q;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/skew_realigner.sv
// Realigns lanes with per-lane upstream skew; suppresses output while a skew change settles.
module skew_realigner
  import skew_realigner_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LANES     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  skew_realigner_if.slave   bus
);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [LANES-1:0]           cfg_q, cfg_d;
  logic                       cfg_mismatch;
  logic                       v1_q, v2_q;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;
  logic [DROP_CNT_W-1:0]      drop_q, drop_d;
  logic [LANES*WORD_SIZE-1:0] out_data_w;

  assign cfg_mismatch = (bus.lane_shift_en != cfg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALIGNED;
      cnt_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
    end
  end

  // Any skew change (re)arms the settle window with the new lane config.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    case (state_q)
      ALIGNED: begin
        if (cfg_mismatch) begin
          cfg_d   = bus.lane_shift_en;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cfg_mismatch) begin
          cfg_d = bus.lane_shift_en;
          cnt_d = CNT_W'(SETTLE_CYCLES);
        end else if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ALIGNED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ALIGNED;
    endcase
  end

  // Next values of the registered outputs; valid beats reaching stage 2 in SETTLE are dropped.
  always_comb begin
    busy_d      = (state_d == SETTLE);
    out_valid_d = v1_q && (state_d == ALIGNED);
    drop_d      = drop_q;
    if ((state_q == SETTLE) && v2_q && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      v1_q        <= bus.in_valid;
      v2_q        <= v1_q;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    lane_delay #(.WORD_SIZE(WORD_SIZE)) u_lane_delay (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en_i (cfg_q[i]),
      .din_i      (bus.in_data[i*WORD_SIZE +: WORD_SIZE]),
      .dout_o     (out_data_w[i*WORD_SIZE +: WORD_SIZE])
    );
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_w;
  assign bus.realign_busy = busy_q;
  assign bus.drop_count   = drop_q;

endmodule

// File: tb/tb_skew_realigner.sv
// Directed bench for skew_realigner: alignment, settle windows, drop saturation, async reset.
module tb_skew_realigner;

  localparam int unsigned WS = 16;
  localparam int unsigned LN = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  skew_realigner_if #(.WORD_SIZE(WS), .LANES(LN)) bus ();

  skew_realigner #(.WORD_SIZE(WS), .LANES(LN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] shift);
    rst_n             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.lane_shift_en = shift;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int lows;
    int busyc;
    errors            = 0;
    checks            = 0;
    rst_n             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.lane_shift_en = '0;

    // Reset state
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data), 64'd0);
    chk("rst_busy",      64'(bus.realign_busy), 64'd0);
    chk("rst_drop",      64'(bus.drop_count), 64'd0);
    tick();
    rst_n = 1'b1;

    // Unskewed lanes: beat at edge 5 is out after edge 7
    repeat (5) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0003_0002_0001_0000;
    tick();
    chk("a_e6_valid", 64'(bus.out_valid), 64'd0);
    chk("a_e6_busy",  64'(bus.realign_busy), 64'd0);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    chk("a_e7_valid", 64'(bus.out_valid), 64'd1);
    chk("a_e7_data",  64'(bus.out_data), 64'h0003_0002_0001_0000);
    chk("a_e7_busy",  64'(bus.realign_busy), 64'd0);
    tick();
    chk("a_e8_valid", 64'(bus.out_valid), 64'd0);

    // Non-zero skew at reset release, then skewed beat
    do_reset(4'b0101);
    tick();
    chk("b_e1_busy", 64'(bus.realign_busy), 64'd1);
    tick();
    chk("b_e2_busy", 64'(bus.realign_busy), 64'd1);
    tick();
    chk("b_e3_busy", 64'(bus.realign_busy), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hAAAA_0000_AAAA_0000;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 64'h1111_5555_1111_5555;
    tick();
    chk("b_valid", 64'(bus.out_valid), 64'd1);
    chk("b_data",  64'(bus.out_data), 64'hAAAA_5555_AAAA_5555);
    chk("b_drop",  64'(bus.drop_count), 64'd0);

    // Single skew change under continuous traffic
    do_reset(4'b0000);
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h1234_5678_9ABC_DEF0;
    repeat (3) tick();
    chk("c_steady_valid", 64'(bus.out_valid), 64'd1);
    bus.lane_shift_en = 4'b0001;
    lows  = 0;
    busyc = 0;
    repeat (6) begin
      tick();
      if (!bus.out_valid) lows++;
      if (bus.realign_busy) busyc++;
    end
    chk("c_low_cycles",  64'(lows), 64'd2);
    chk("c_busy_cycles", 64'(busyc), 64'd2);
    chk("c_drop",        64'(bus.drop_count), 64'd2);
    chk("c_data",        64'(bus.out_data), 64'h1234_5678_9ABC_DEF0);

    // Second change one cycle into SETTLE extends the window
    do_reset(4'b0000);
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.lane_shift_en = 4'b0001;
    tick();
    busyc = bus.realign_busy ? 1 : 0;
    bus.lane_shift_en = 4'b0000;
    repeat (6) begin
      tick();
      if (bus.realign_busy) busyc++;
    end
    chk("d_busy_cycles", 64'(busyc), 64'd3);
    chk("d_drop",        64'(bus.drop_count), 64'd3);

    // Long SETTLE saturates drop_count
    for (int i = 0; i < 300; i++) begin
      bus.lane_shift_en = bus.lane_shift_en ^ 4'b0001;
      tick();
    end
    chk("e_busy_long", 64'(bus.realign_busy), 64'd1);
    chk("e_drop_sat",  64'(bus.drop_count), 64'd255);
    repeat (5) tick();
    chk("e_drop_hold", 64'(bus.drop_count), 64'd255);
    chk("e_busy_end",  64'(bus.realign_busy), 64'd0);
    chk("e_valid_end", 64'(bus.out_valid), 64'd1);

    // Asynchronous reset mid-SETTLE
    bus.lane_shift_en = bus.lane_shift_en ^ 4'b0001;
    tick();
    chk("f_busy_pre", 64'(bus.realign_busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("f_valid_async", 64'(bus.out_valid), 64'd0);
    chk("f_drop_async",  64'(bus.drop_count), 64'd0);
    chk("f_busy_async",  64'(bus.realign_busy), 64'd0);
    chk("f_data_async",  64'(bus.out_data), 64'd0);

    // Restart after aborted SETTLE: first valid out 2 cycles after first in_valid
    bus.in_valid      = 1'b0;
    bus.lane_shift_en = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("g_idle_valid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1;
    tick();
    chk("g_k1_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("g_k2_valid", 64'(bus.out_valid), 64'd1);
    chk("g_k2_busy",  64'(bus.realign_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skew_realigner.md
SKEW_REALIGNER -- requirements
Module: skew_realigner

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the bit width of one lane word.
REQ-002 Parameter LANES, default 4, SHALL set the number of parallel lanes.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 in_valid  input  1  SHALL qualify in_data, timed to the un-shifted lanes.
REQ-006 in_data  input  LANES*WORD_SIZE  SHALL carry the lane words, lane i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-007 lane_shift_en  input  LANES  SHALL mark which lanes are delayed upstream; bit i=1 means lane i arrives one cycle late (stalled stage active).
REQ-008 out_valid  output  1  SHALL qualify out_data as a fully aligned word.
REQ-009 out_data  output  LANES*WORD_SIZE  SHALL carry the realigned lane words, same lane packing as in_data.
REQ-010 realign_busy  output  1  SHALL be high while the block is in the SETTLE state.
REQ-011 drop_count  output  8  SHALL count valid beats suppressed during SETTLE.

Function
REQ-012 Each lane with lane_shift_en[i]=1 SHALL pass through exactly one register stage.
REQ-013 Each lane with lane_shift_en[i]=0 SHALL pass through exactly two register stages.
REQ-014 The valid pipeline SHALL be two stages, so out_valid is in_valid delayed by 2 cycles.
REQ-015 Net effect: a word presented to un-shifted lanes at edge t, and to shifted lanes at edge t+1, SHALL appear on out_data in full after edge t+2.
REQ-016 The block SHALL hold a registered copy cfg_q of lane_shift_en and compare it against lane_shift_en every cycle.
REQ-017 FSM states SHALL be ALIGNED and SETTLE.
REQ-018 In ALIGNED, a mismatch between lane_shift_en and cfg_q at a rising edge SHALL cause: cfg_q <= lane_shift_en, settle counter <= 2, state <= SETTLE.
REQ-019 In SETTLE, the settle counter SHALL decrement each cycle, and the state SHALL return to ALIGNED on the edge where the counter is 1.
REQ-020 A further mismatch while in SETTLE SHALL reload the counter to 2, update cfg_q, and keep the state in SETTLE.
REQ-021 In SETTLE, out_valid SHALL be forced to 0; out_data keeps shifting but is don't-care.
REQ-022 On each SETTLE cycle where the internal stage-2 valid is 1, drop_count SHALL increment, saturating at 255.
REQ-023 The lane stage selection (REQ-012/013) SHALL use cfg_q, never the raw lane_shift_en.
REQ-024 in_valid=0 beats SHALL propagate as bubbles, with no effect on the FSM or drop_count.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously clear out_valid, out_data, all pipeline registers, drop_count and the settle counter, and set cfg_q=0 with state=ALIGNED.
REQ-026 A reset asserted mid-SETTLE SHALL abort SETTLE; after release, out_valid SHALL first be high 2 cycles after the first in_valid.
REQ-027 If lane_shift_en is non-zero at reset release, the first edge SHALL enter SETTLE per REQ-018.

Structure
REQ-028 A shared package SHALL hold the state enum {ALIGNED, SETTLE}, the SETTLE_CYCLES=2 constant, and the DROP_CNT_W=8 constant.
REQ-029 A single sub-module, lane_delay, SHALL implement one lane's selectable one- or two-stage delay and be instantiated LANES times.

Verification
REQ-030 Reset, then lane_shift_en=0000 held, in_valid=1 with in_data lanes {0x0003,0x0002,0x0001,0x0000} at edge 5 -> out_valid=1 with the same data after edge 7, realign_busy=0 throughout.
REQ-031 lane_shift_en=0101 at reset release: edge 1 enters SETTLE and realign_busy is high for 2 cycles; then lanes 1,3=0xAAAA at edge t and lanes 0,2=0x5555 at edge t+1 -> out_data lanes {0xAAAA,0x5555,0xAAAA,0x5555} (lanes 3..0) valid after edge t+2.
REQ-032 Continuous in_valid=1 while lane_shift_en toggles 0000->0001 -> exactly 2 cycles of out_valid=0 and drop_count=2.
REQ-033 lane_shift_en toggles again 1 cycle into SETTLE -> realign_busy stays high for 3 consecutive cycles total and drop_count=3.
REQ-034 Force 300 SETTLE cycles with in_valid=1 -> drop_count=255 and holds.
REQ-035 Assert rst_n=0 mid-SETTLE -> out_valid=0, drop_count=0 and realign_busy=0 immediately, without waiting for a clock edge.
